div_seq_16: RTL

//  Iterative radix-2 restoring divider, the subtraction-side counterpart of the ALU adder chain.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_sub_stage.sv | 20 ++
 rtl/div_seq_16.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and the
// divide-by-zero quotient constant.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    localparam int unsigned DIV_MAX_W = 64;

    // All-ones quotient for a zero divisor; callers truncate to their width.
    function automatic logic [DIV_MAX_W-1:0] div_zero_q();
        return '1;
    endfunction

endpackage

// File: rtl/div_sub_stage.sv
// W-bit subtractor (a + ~b + 1) returning difference and borrow; used for the
// restoring trial subtraction and for two's-complement negation.
module div_sub_stage #(
    parameter int unsigned W = 17
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    localparam int unsigned SW = W + 1;

    logic [SW-1:0] sum_c;

    assign sum_c    = {1'b0, a_i} + {1'b0, ~b_i} + SW'(1);
    assign diff_o   = sum_c[W-1:0];
    assign borrow_o = ~sum_c[W];

endmodule

// File: rtl/div_seq_16.sv
// Iterative radix-2 restoring divider behind a valid/ready handshake.
// Signed operation is built only when DIV_SIGNED_EN is defined.
module div_seq_16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             op_signed,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    import div_pkg::*;

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned TW    = WIDTH + 1;

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             zero_q, zero_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] quo_out_q, quo_out_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             dbz_q, dbz_d;

    logic             accept_c;
    logic [WIDTH-1:0] mag_dvd_c, mag_dvs_c;
    logic [WIDTH-1:0] fix_quo_c, fix_rem_c;
    logic [TW-1:0]    rem_shift_c, trial_diff_c;
    logic             trial_borrow_c;
    logic             unused_trial_msb_c;

    assign accept_c = (state_q == ST_IDLE) && in_valid && in_ready_q;

    // Trial subtraction of the divisor from the shifted partial remainder.
    assign rem_shift_c        = {rem_q, q_q[WIDTH-1]};
    assign unused_trial_msb_c = trial_diff_c[WIDTH];

    div_sub_stage #(.W(TW)) u_trial (
        .a_i      (rem_shift_c),
        .b_i      ({1'b0, dvs_q}),
        .diff_o   (trial_diff_c),
        .borrow_o (trial_borrow_c)
    );

`ifdef DIV_SIGNED_EN
    logic             sgn_quo_q, sgn_rem_q;
    logic [WIDTH-1:0] neg_dvd_c, neg_dvs_c, neg_quo_c, neg_rem_c;
    logic [3:0]       unused_borrow_c;

    div_sub_stage #(.W(WIDTH)) u_neg_dvd (
        .a_i('0), .b_i(dividend), .diff_o(neg_dvd_c), .borrow_o(unused_borrow_c[0]));
    div_sub_stage #(.W(WIDTH)) u_neg_dvs (
        .a_i('0), .b_i(divisor),  .diff_o(neg_dvs_c), .borrow_o(unused_borrow_c[1]));
    div_sub_stage #(.W(WIDTH)) u_neg_quo (
        .a_i('0), .b_i(q_q),      .diff_o(neg_quo_c), .borrow_o(unused_borrow_c[2]));
    div_sub_stage #(.W(WIDTH)) u_neg_rem (
        .a_i('0), .b_i(rem_q),    .diff_o(neg_rem_c), .borrow_o(unused_borrow_c[3]));

    assign mag_dvd_c = (op_signed && dividend[WIDTH-1]) ? neg_dvd_c : dividend;
    assign mag_dvs_c = (op_signed && divisor[WIDTH-1])  ? neg_dvs_c : divisor;
    assign fix_quo_c = sgn_quo_q ? neg_quo_c : q_q;
    assign fix_rem_c = sgn_rem_q ? neg_rem_c : rem_q;

    // Result signs captured with the operands, applied once in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            sgn_quo_q <= 1'b0;
            sgn_rem_q <= 1'b0;
        end else if (accept_c) begin
            sgn_quo_q <= op_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sgn_rem_q <= op_signed && dividend[WIDTH-1];
        end
    end
`else
    logic unused_op_signed_c;

    assign unused_op_signed_c = op_signed;
    assign mag_dvd_c          = dividend;
    assign mag_dvs_c          = divisor;
    assign fix_quo_c          = q_q;
    assign fix_rem_c          = rem_q;
`endif

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        q_d         = q_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        quo_out_d   = quo_out_q;
        rem_out_d   = rem_out_q;
        dbz_d       = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    q_d     = mag_dvd_c;
                    dvs_d   = mag_dvs_c;
                    count_d = '0;
                    zero_d  = (divisor == '0);
                    // A zero divisor parks |dividend| as the remainder and skips CALC.
                    rem_d   = (divisor == '0) ? mag_dvd_c : '0;
                    state_d = (divisor == '0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (!trial_borrow_c) begin
                    rem_d = trial_diff_c[WIDTH-1:0];
                    q_d   = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift_c[WIDTH-1:0];
                    q_d   = {q_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // First DONE cycle publishes the sign-corrected result.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    dbz_d       = zero_q;
                    quo_out_d   = zero_q ? WIDTH'(div_zero_q()) : fix_quo_c;
                    rem_out_d   = fix_rem_c;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (kill) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end

        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            q_q         <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quo_out_q   <= '0;
            rem_out_q   <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            q_q         <= q_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            quo_out_q   <= quo_out_d;
            rem_out_q   <= rem_out_d;
            dbz_q       <= dbz_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quo_out_q;
    assign remainder   = rem_out_q;
    assign div_by_zero = dbz_q;

endmodule
